// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl : fixed-priority interrupt controller upstream of instruction fetch.
//
// Collects eight peripheral request lines into a pending register. Each source
// is qualified by a per-source mask and a global enable (GIE), and the lowest
// eligible index wins arbitration. The controller drives a one-hot redirect to
// the fetch stage for one cycle, saves the return PC, and blocks further
// dispatch until the handler signals return.
//
// Build option:
//   INTC_EDGE_EN  defined   : a rising edge on irq_src[i] sets pending[i].
//                 undefined : level mode. pending[i] is set every cycle that
//                             irq_src[i] is high, and no edge-history flops
//                             are built.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   irq_src    in   [7:0] request lines (0 timer, 1 uart, 2 bt, 7:3 spare)
//   jump_flag  in   fetch redirect by branch/jump this cycle
//   pc_in      in   [CPU_WIDTH-1:0] current fetch PC
//   iret       in   one-cycle handler-return pulse
//   reg_we     in   register write strobe
//   reg_addr   in   [1:0] 0 MASK, 1 PEND (W1C), 2 STAT, 3 EPC (RO)
//   reg_wdata  in   [CPU_WIDTH-1:0] write data
//   reg_rdata  out  [CPU_WIDTH-1:0] combinational read data
//   irq        out  [7:0] one-hot dispatch vector; masked by jump_flag
//   epc        out  [CPU_WIDTH-1:0] saved return address
//   in_service out  high from dispatch until iret
// -----------------------------------------------------------------------------
module int_ctrl #(
    parameter int unsigned CPU_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           irq_src,
    input  logic                 jump_flag,
    input  logic [CPU_WIDTH-1:0] pc_in,
    input  logic                 iret,
    input  logic                 reg_we,
    input  logic [1:0]           reg_addr,
    input  logic [CPU_WIDTH-1:0] reg_wdata,
    output logic [CPU_WIDTH-1:0] reg_rdata,
    output logic [7:0]           irq,
    output logic [CPU_WIDTH-1:0] epc,
    output logic                 in_service
);

    localparam int unsigned IRQ_NUM = 8;
    localparam int unsigned ID_W    = 3;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DISPATCH = 2'd1;
    localparam logic [1:0] ST_SERVICE  = 2'd2;

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_PEND = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_EPC  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [CPU_WIDTH-1:0] epc_q, epc_d;
    logic [IRQ_NUM-1:0]   pend_q, pend_d;
    logic [IRQ_NUM-1:0]   mask_q, mask_d;
    logic                 gie_q, gie_d;

    logic [IRQ_NUM-1:0]   set_vec;
    logic [IRQ_NUM-1:0]   eligible;
    logic [IRQ_NUM-1:0]   disp_clr;
    logic [IRQ_NUM-1:0]   w1c_clr;
    logic [ID_W-1:0]      prio_id;
    logic                 prio_hit;

    // Only the low byte of write data is architecturally meaningful.
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata[CPU_WIDTH-1:IRQ_NUM];

    // Request capture: edge detect or raw level depending on build option.
`ifdef INTC_EDGE_EN
    logic [IRQ_NUM-1:0] src_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= '0;
        end else begin
            src_q <= irq_src;
        end
    end

    assign set_vec = irq_src & ~src_q;
`else
    assign set_vec = irq_src;
`endif

    assign eligible = gie_q ? (pend_q & mask_q) : '0;

    // Fixed priority: scanning downward lets the lowest set index win.
    always_comb begin
        prio_id  = '0;
        prio_hit = 1'b0;
        for (int i = int'(IRQ_NUM) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                prio_id  = ID_W'(i);
                prio_hit = 1'b1;
            end
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            epc_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            gie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            epc_q   <= epc_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            gie_q   <= gie_d;
        end
    end

    // Next-state: arbitration result is frozen into id_q on entry to DISPATCH,
    // so later MASK/GIE writes cannot cancel an in-flight dispatch.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        epc_d    = epc_q;
        disp_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if (prio_hit && !jump_flag) begin
                    state_d  = ST_DISPATCH;
                    id_d     = prio_id;
                    disp_clr = IRQ_NUM'(1) << prio_id;
                end
            end
            ST_DISPATCH: begin
                // A concurrent branch defers the redirect; the retry then
                // captures the branch target as the return address.
                if (!jump_flag) begin
                    epc_d   = pc_in;
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (iret) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register writes; a new request always beats a clear of the same bit.
    always_comb begin
        mask_d  = mask_q;
        gie_d   = gie_q;
        w1c_clr = '0;
        if (reg_we) begin
            case (reg_addr)
                A_MASK:  mask_d  = reg_wdata[IRQ_NUM-1:0];
                A_PEND:  w1c_clr = reg_wdata[IRQ_NUM-1:0];
                A_STAT:  gie_d   = reg_wdata[0];
                default: ;
            endcase
        end
        pend_d = (pend_q & ~(w1c_clr | disp_clr)) | set_vec;
    end

    // Redirect is suppressed combinationally whenever fetch is already jumping.
    always_comb begin
        irq = '0;
        if ((state_q == ST_DISPATCH) && !jump_flag) begin
            irq = IRQ_NUM'(1) << id_q;
        end
    end

    assign in_service = (state_q != ST_IDLE);
    assign epc        = epc_q;

    // Register read mux; unused upper bits are zero.
    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            A_MASK:  reg_rdata = CPU_WIDTH'(mask_q);
            A_PEND:  reg_rdata = CPU_WIDTH'(pend_q);
            A_STAT:  reg_rdata = CPU_WIDTH'({id_q, in_service, gie_q});
            A_EPC:   reg_rdata = epc_q;
            default: reg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl : randomized and directed bench for int_ctrl with a behavioural
// reference model. Expected irq vectors go into a queue at stimulus time and
// a separate monitor pops and compares them whenever the DUT drives irq.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq_src;
    logic        jump_flag;
    logic [15:0] pc_in;
    logic        iret;
    logic        reg_we;
    logic [1:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;
    logic [7:0]  irq;
    logic [15:0] epc;
    logic        in_service;

    int n_checks   = 0;
    int n_fail     = 0;
    int n_irq_seen = 0;
    int rd_ptr     = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    // Reference model: phase 0 = waiting, 1 = redirect owed, 2 = in handler.
    logic [7:0]  m_pend;
    logic [7:0]  m_mask;
    logic [7:0]  m_prev;
    logic        m_gie;
    int          m_phase;
    int          m_id;
    logic [15:0] m_epc;

    int_ctrl #(.CPU_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_src    (irq_src),
        .jump_flag  (jump_flag),
        .pc_in      (pc_in),
        .iret       (iret),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .irq        (irq),
        .epc        (epc),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] model_rdata(input logic [1:0] ad);
        case (ad)
            2'd0:    return {8'h00, m_mask};
            2'd1:    return {8'h00, m_pend};
            2'd2:    return 16'(m_id * 4 + ((m_phase != 0) ? 2 : 0) + (m_gie ? 1 : 0));
            default: return m_epc;
        endcase
    endfunction

    // Monitor: every driven irq must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && (irq != 8'h00 || exp_q.size() != 0)) begin
            if (exp_q.size() == 0) begin
                chk("irq_unexpected", irq, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("irq", irq, mon_exp);
            end
            if (irq != 8'h00) begin
                chk("irq_with_jump", jump_flag, 0);
                n_irq_seen++;
            end
        end
    end

    // One clock of stimulus: entered and left at posedge+1.
    task automatic step(input logic [7:0] src, input logic jf, input logic [15:0] pc,
                        input logic ir, input logic we, input logic [1:0] ad,
                        input logic [15:0] wd);
        logic [7:0] elig;
        logic [7:0] setv;
        logic [7:0] clr;
        irq_src   = src;
        jump_flag = jf;
        pc_in     = pc;
        iret      = ir;
        reg_we    = we;
        reg_addr  = ad;
        reg_wdata = wd;
        if (m_phase == 1 && !jf) exp_q.push_back(8'(1 << m_id));
        @(negedge clk);
        chk("in_service", 32'(in_service), 32'(m_phase != 0));
        chk("epc", epc, m_epc);
        chk("reg_rdata", reg_rdata, model_rdata(ad));
        @(posedge clk);
        elig = m_gie ? (m_pend & m_mask) : 8'h00;
`ifdef INTC_EDGE_EN
        setv = src & ~m_prev;
`else
        setv = src;
`endif
        clr = 8'h00;
        if (m_phase == 0) begin
            if (elig != 8'h00 && !jf) begin
                m_id    = lowest(elig);
                clr     = 8'(1 << m_id);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!jf) begin
                m_epc   = pc;
                m_phase = 2;
            end
        end else if (ir) begin
            m_phase = 0;
        end
        if (we) begin
            if (ad == 2'd0) m_mask = wd[7:0];
            if (ad == 2'd1) clr = clr | wd[7:0];
            if (ad == 2'd2) m_gie = wd[0];
        end
        m_pend = (m_pend & ~clr) | setv;
        m_prev = src;
        #1;
    endtask

    task automatic cyc(input logic [7:0] src, input logic jf, input logic [15:0] pc, input logic ir);
        step(src, jf, pc, ir, 1'b0, 2'(rd_ptr), 16'h0000);
        rd_ptr++;
    endtask

    task automatic wr(input logic [1:0] ad, input logic [15:0] wd);
        step(8'h00, 1'b0, 16'($urandom), 1'b0, 1'b1, ad, wd);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        irq_src   = 8'h00;
        jump_flag = 1'b0;
        pc_in     = 16'h0000;
        iret      = 1'b0;
        reg_we    = 1'b0;
        reg_wdata = 16'h0000;
        for (int a = 0; a < 4; a++) begin
            reg_addr = 2'(a);
            @(negedge clk);
            chk("rst_irq", irq, 0);
            chk("rst_in_service", 32'(in_service), 0);
            chk("rst_epc", epc, 0);
            chk("rst_rdata", reg_rdata, 0);
            @(posedge clk);
            #1;
        end
        m_pend  = 8'h00;
        m_mask  = 8'h00;
        m_prev  = 8'h00;
        m_gie   = 1'b0;
        m_phase = 0;
        m_id    = 0;
        m_epc   = 16'h0000;
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        do_reset();

        // Single uart pulse.
        wr(2'd0, 16'h0007);
        wr(2'd2, 16'h0001);
        base = n_irq_seen;
        cyc(8'h02, 1'b0, 16'h0100, 1'b0);
        cyc(8'h00, 1'b0, 16'h0102, 1'b0);
        cyc(8'h00, 1'b0, 16'h1234, 1'b0);
        cyc(8'h00, 1'b0, 16'h1236, 1'b0);
        chk("uart_once", n_irq_seen - base, 1);
        chk("uart_epc", epc, 16'h1234);
        cyc(8'h00, 1'b0, 16'h0000, 1'b1);

        // uart and bt together: uart first, bt after iret.
        cyc(8'h06, 1'b0, 16'h0200, 1'b0);
        for (int k = 0; k < 4; k++) cyc(8'h00, 1'b0, 16'(16'h0210 + k), 1'b0);
        cyc(8'h00, 1'b0, 16'h0220, 1'b1);
        for (int k = 0; k < 4; k++) cyc(8'h00, 1'b0, 16'(16'h0230 + k), 1'b0);
        cyc(8'h00, 1'b0, 16'h0240, 1'b1);

        // Branch collides with dispatch for three cycles.
        cyc(8'h01, 1'b0, 16'h0300, 1'b0);
        cyc(8'h00, 1'b0, 16'h0302, 1'b0);
        for (int k = 0; k < 3; k++) cyc(8'h00, 1'b1, 16'h0040, 1'b0);
        cyc(8'h00, 1'b0, 16'h0040, 1'b0);
        cyc(8'h00, 1'b0, 16'h0042, 1'b0);
        chk("jump_epc", epc, 16'h0040);
        cyc(8'h00, 1'b0, 16'h0044, 1'b1);

        // Masked source stays pending; W1C then unmask gives nothing.
        wr(2'd0, 16'h0000);
        cyc(8'h01, 1'b0, 16'h0400, 1'b0);
        cyc(8'h00, 1'b0, 16'h0402, 1'b0);
        cyc(8'h00, 1'b0, 16'h0404, 1'b0);
        wr(2'd1, 16'h0001);
        wr(2'd0, 16'h0001);
        base = n_irq_seen;
        for (int k = 0; k < 4; k++) cyc(8'h00, 1'b0, 16'h0410, 1'b0);
        chk("no_dispatch_after_w1c", n_irq_seen - base, 0);

        // Timer re-raised during service is held and dispatched after iret.
        cyc(8'h01, 1'b0, 16'h0500, 1'b0);
        cyc(8'h00, 1'b0, 16'h0502, 1'b0);
        cyc(8'h00, 1'b0, 16'h0504, 1'b0);
        cyc(8'h01, 1'b0, 16'h0506, 1'b0);
        cyc(8'h00, 1'b0, 16'h0508, 1'b1);
        cyc(8'h00, 1'b0, 16'h050a, 1'b0);
        cyc(8'h00, 1'b0, 16'h050c, 1'b0);
        cyc(8'h00, 1'b0, 16'h050e, 1'b0);
        do_reset();

        // Source held high for ten cycles with periodic iret.
        wr(2'd0, 16'h0001);
        wr(2'd2, 16'h0001);
        base = n_irq_seen;
        for (int k = 0; k < 10; k++) cyc(8'h01, 1'b0, 16'(16'h0600 + 2 * k), (k % 3 == 2));
        for (int k = 0; k < 6; k++) cyc(8'h00, 1'b0, 16'(16'h0700 + 2 * k), 1'b1);
`ifdef INTC_EDGE_EN
        chk("hold_single_dispatch", n_irq_seen - base, 1);
`else
        chk("hold_repeat_dispatch", 32'((n_irq_seen - base) >= 2), 1);
`endif
        wr(2'd1, 16'h00ff);

        // Randomized traffic with occasional register writes and resets.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] s;
            s = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 9) == 0) begin
                logic [1:0] ad;
                ad = 2'($urandom);
                step(s, 1'($urandom_range(0, 3) == 0), 16'($urandom), 1'($urandom_range(0, 4) == 0),
                     1'b1, ad, (ad == 2'd2) ? 16'($urandom_range(0, 3) != 0) : 16'($urandom));
            end else begin
                step(s, 1'($urandom_range(0, 3) == 0), 16'($urandom), 1'($urandom_range(0, 4) == 0),
                     1'b0, 2'($urandom), 16'($urandom));
            end
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
